// File: rtl/seq_tx_pkg.sv
// Shared types and default sizes for the serial pattern transmitter.
// Optional loop feature: SEQ_TX_REPEAT_EN.
package seq_tx_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_e;

    typedef enum logic [1:0] {
        SR_CLR,
        SR_LOAD,
        SR_SHIFT,
        SR_RELOAD
    } sr_op_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// Parallel-load, MSB-out shift register with effective-length alignment.
// Reload-from-capture path exists only with SEQ_TX_REPEAT_EN.
module seq_tx_shreg
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  sr_op_e           op,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] eff_len,
    output logic             msb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] aligned;

    // Move bit N-1 up to the MSB so every length shifts out the same way.
    assign aligned = pattern << (LEN_W'(WIDTH) - eff_len);

`ifdef SEQ_TX_REPEAT_EN
    logic [WIDTH-1:0] saved_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            saved_q <= '0;
        end else if (op == SR_LOAD) begin
            saved_q <= aligned;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            unique case (op)
                SR_LOAD:   data_q <= aligned;
                SR_SHIFT:  data_q <= data_q << 1;
`ifdef SEQ_TX_REPEAT_EN
                SR_RELOAD: data_q <= saved_q;
`endif
                default:   data_q <= '0;
            endcase
        end
    end

    assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: FSM and bit counter around seq_tx_shreg.
// Optional loop feature: SEQ_TX_REPEAT_EN.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             stop,
    input  logic             repeat_req,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] eff_len;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             last;
    sr_op_e           op;

    assign eff_len = (len == '0 || len > LEN_W'(WIDTH))
                   ? LEN_W'(WIDTH) : len;
    assign last    = (cnt_q <= LEN_W'(1));

`ifdef SEQ_TX_REPEAT_EN
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
        end else if (op == SR_LOAD) begin
            len_q <= eff_len;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = repeat_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        op      = SR_CLR;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    op      = SR_LOAD;
                    state_d = SHIFT;
                    cnt_d   = eff_len;
                    valid_d = 1'b1;
                    done_d  = (eff_len == LEN_W'(1));
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!last) begin
                    op      = SR_SHIFT;
                    cnt_d   = cnt_q - LEN_W'(1);
                    valid_d = 1'b1;
                    done_d  = (cnt_q == LEN_W'(2));
                end else if (start) begin
                    op      = SR_LOAD;
                    cnt_d   = eff_len;
                    valid_d = 1'b1;
                    done_d  = (eff_len == LEN_W'(1));
`ifdef SEQ_TX_REPEAT_EN
                end else if (repeat_req) begin
                    op      = SR_RELOAD;
                    cnt_d   = len_q;
                    valid_d = 1'b1;
                    done_d  = (len_q == LEN_W'(1));
`endif
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    seq_tx_shreg #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .op     (op),
        .pattern(pattern),
        .eff_len(eff_len),
        .msb    (x)
    );

    assign x_valid = valid_q;
    assign busy    = valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a per-cycle expected-output queue.
// Loop scenarios are exercised when SEQ_TX_REPEAT_EN is defined.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic       stop = 1'b0;
    logic       repeat_req = 1'b0;
    logic       x, x_valid, busy, done;

    logic [3:0] expq[$];
    int vectors = 0;
    int miscompares = 0;

    seq_pattern_tx dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .stop      (stop),
        .repeat_req(repeat_req),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected {x, x_valid, busy, done} for each bit, MSB first.
    task automatic push_pattern(input logic [7:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            expq.push_back({pat[i], 1'b1, 1'b1, (i == 0)});
        end
    endtask

    task automatic sendp(input logic [7:0] pat, input logic [3:0] l,
                         input int n);
        pattern = pat;
        len     = l;
        start   = 1'b1;
        push_pattern(pat, n);
    endtask

    task automatic tick(input string tag);
        logic [3:0] exp_v;
        logic [3:0] got;
        @(posedge clk);
        #1;
        exp_v = (expq.size() != 0) ? expq.pop_front() : 4'b0000;
        got   = {x, x_valid, busy, done};
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s: x/v/b/d got %b required %b", tag, got, exp_v);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        ticks(2, "reset");
        reset = 1'b0;
        tick("idle0");

        sendp(8'b00101010, 4'd8, 8);
        ticks(8, "basic");
        tick("basic_idle");

        sendp(8'b11111101, 4'd3, 3);
        ticks(3, "len3");
        tick("len3_idle");

        sendp(8'hA5, 4'd0, 8);
        ticks(8, "len0");
        tick("len0_idle");

        sendp(8'h3C, 4'd15, 8);
        ticks(8, "len15");
        tick("len15_idle");

        sendp(8'hFF, 4'd1, 1);
        tick("len1");
        tick("len1_idle");

        sendp(8'b00101010, 4'd8, 8);
        ticks(8, "b2b_a");
        sendp(8'hF0, 4'd8, 8);
        ticks(8, "b2b_b");
        tick("b2b_idle");

        sendp(8'hC3, 4'd8, 8);
        ticks(2, "abort_pre");
        pattern = 8'h00;
        len     = 4'd2;
        start   = 1'b1;
        ticks(2, "ign_start");
        stop  = 1'b1;
        start = 1'b1;
        expq.delete();
        tick("stop");
        tick("stop_idle");

        stop  = 1'b1;
        start = 1'b1;
        pattern = 8'hFF;
        tick("idle_start_stop");
        stop = 1'b1;
        tick("idle_stop");

        sendp(8'h96, 4'd8, 8);
        ticks(3, "rst_pre");
        reset = 1'b1;
        start = 1'b1;
        expq.delete();
        tick("rst_mid");
        reset = 1'b0;
        tick("rst_idle");
        sendp(8'h5A, 4'd8, 8);
        ticks(8, "rst_fresh");
        tick("rst_fresh_idle");

`ifdef SEQ_TX_REPEAT_EN
        repeat_req = 1'b1;
        sendp(8'b00001001, 4'd4, 4);
        pattern = 8'hFF;
        ticks(4, "rpt_1");
        push_pattern(8'b00001001, 4);
        ticks(4, "rpt_2");
        push_pattern(8'b00001001, 4);
        ticks(2, "rpt_3");
        repeat_req = 1'b0;
        ticks(2, "rpt_3");
        tick("rpt_idle");

        repeat_req = 1'b1;
        sendp(8'h0F, 4'd4, 4);
        ticks(4, "prio_a");
        sendp(8'hAA, 4'd8, 8);
        repeat_req = 1'b0;
        ticks(8, "prio_b");
        tick("prio_idle");
`else
        repeat_req = 1'b1;
        sendp(8'b00001001, 4'd4, 4);
        ticks(4, "rpt_off");
        tick("rpt_off_idle");
        repeat_req = 1'b0;
`endif

        vectors++;
        assert (expq.size() == 0) else begin
            miscompares++;
            $error("FAIL queue_drain: left %0d required 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
